pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 24-bit pipelined datapath. It produces the fetch/decode stall, decode/execute flush and ALU operand forwarding selects. It keeps its own execute-stage copy of the decode source-register addresses, plus a small FSM that freezes fetch while a PC-redirecting instruction is in flight. A saturating stall counter is exposed for performance checks.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter
- PC_REG, 4'd15, register index aliased to PC (never hazards, never forwarded)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra1D, ra2D  in  4  decode-stage source addresses (post ra1Src/ra2Src mux)
- useRa1D, useRa2D  in  1  source actually read by decode instruction
- PCSrcD  in  1  decode instruction will redirect PC
- regWriteE, memToRegE  in  1  execute-stage controls
- WA3E  in  4  execute-stage destination
- regWriteM  in  1  memory-stage write enable
- WA3M  in  4  memory-stage destination
- regWriteW, PCSrcW  in  1  writeback controls
- WA3W  in  4  writeback destination
- stallF, stallD  out  1  hold PC register / decode register
- flushD, flushE  out  1  clear decode / execute pipeline register (bubble)
- fwdAE, fwdBE  out  2  srcA/srcB select: 00 regfile, 01 resultW, 10 ALU result of M
- busy  out  1  FSM not in RUN
- stallCount  out  CNT_W  cycles with stallF=1, saturating

## Operation
- Internal E-stage copies ra1E, ra2E (4 b), use1E, use2E (1 b). Each edge: if flushE, clear use1E/use2E to 0 (addresses retain their value); else load ra*D/useRa*D.
- Forwarding (combinational, per operand X in {1,2}):
  - 10 if useXE, regWriteM, WA3M==raXE, raXE!=PC_REG.
  - Else 01 if useXE, regWriteW, WA3W==raXE, raXE!=PC_REG.
  - Else 00.
  - M beats W on a double match.
- Load-use hazard ldStall = regWriteE & memToRegE & ((useRa1D & WA3E==ra1D & ra1D!=PC_REG) | (useRa2D & WA3E==ra2D & ra2D!=PC_REG)).
- FSM states:
  - RUN: outputs stallF=stallD=ldStall, flushE=ldStall, flushD=0.
    - PCSrcD & !ldStall: next state BR_WAIT.
    - PCSrcD & ldStall: stay in RUN; the branch stays in decode and is re-evaluated next cycle.
  - BR_WAIT: stallF=1, flushD=1, stallD=0, flushE=0.
    - PCSrcW=1: next state RUN. The redirected PC loads that cycle because PCSrcW drives the PC mux; the stallF output is 0 in that cycle.
    - ldStall is ignored in BR_WAIT (decode holds only bubbles).
- busy = (state != RUN).
- stallCount increments each cycle stallF=1 and holds at all-ones.

## Timing
- All outputs except stallCount and busy are combinational from inputs and registered state; zero-cycle latency.
- Reset values: state=RUN, use1E=use2E=0, ra1E=ra2E=0, stallCount=0.
- Outputs after reset with idle inputs: stallF=stallD=flushD=flushE=0, fwdAE=fwdBE=00, busy=0.
- Load-use stall lasts exactly 1 cycle per hazard. The next cycle the load is in M and is forwarded via 10.
- BR_WAIT length is determined by PCSrcW arrival, normally 3 cycles after entry. There is no timeout.
- Reset asserted mid-BR_WAIT or mid-stall: next edge returns to RUN with reset values; stallCount clears.
- PCSrcW=1 while in RUN (unexpected): no effect on state; stallF is forced to 0 that cycle.

## Structure
- Shared package pipe_pkg:
  - typedef state_t {RUN, BR_WAIT}
  - typedef fwd_t with constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - localparam PC_REG
- One sub-module fwd_sel, instantiated twice (A and B). Inputs raXE, useXE, WA3M, regWriteM, WA3W, regWriteW; output is the 2-bit select.
- The top level holds the E-stage address register, load-use detect, FSM and counter.

## Test plan
- Reset then idle inputs → all outputs 0/00, busy=0, stallCount=0.
- Producer in M with WA3M=3, regWriteM=1, and E-stage ra1E=3 (loaded the prior cycle) → fwdAE=10. Same with WA3W=3 also set → still 10. ra1E=15 → 00.
- Load in E (WA3E=5, memToRegE=1, regWriteE=1), decode useRa2D=1, ra2D=5 → exactly one cycle of stallF=stallD=flushE=1. Next cycle fwdBE=10 once the load reaches M.
- PCSrcD=1 with no hazard → BR_WAIT: stallF=flushD=1 for 3 cycles. PCSrcW on the 4th cycle → back to RUN. stallCount=3.
- PCSrcD=1 together with a load-use hazard → 1 load-use stall cycle in RUN, then BR_WAIT entry.
- rst pulsed during BR_WAIT → RUN next cycle, stallCount=0. Force 2^CNT_W+5 stall cycles → stallCount saturates at all-ones.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select encoding and the PC-aliased register index.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ALU operand forwarding select for one execute-stage source operand.
// Purely combinational; the memory-stage producer wins over writeback.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter logic [3:0] PC_REG_IDX = PC_REG
) (
  input  logic [3:0] ra_e_i,
  input  logic       use_e_i,
  input  logic [3:0] wa3_m_i,
  input  logic       reg_write_m_i,
  input  logic [3:0] wa3_w_i,
  input  logic       reg_write_w_i,
  output fwd_t       sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    // PC reads come from the PC path, never from a bypass.
    if (use_e_i && (ra_e_i != PC_REG_IDX)) begin
      if (reg_write_m_i && (wa3_m_i == ra_e_i)) begin
        sel_o = FWD_M;
      end else if (reg_write_w_i && (wa3_w_i == ra_e_i)) begin
        sel_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller: E-stage source copy, load-use detect,
// branch-wait FSM freezing fetch until PCSrcW, and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int         CNT_W  = 16,
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ra1D,
  input  logic [3:0]       ra2D,
  input  logic             useRa1D,
  input  logic             useRa2D,
  input  logic             PCSrcD,
  input  logic             regWriteE,
  input  logic             memToRegE,
  input  logic [3:0]       WA3E,
  input  logic             regWriteM,
  input  logic [3:0]       WA3M,
  input  logic             regWriteW,
  input  logic             PCSrcW,
  input  logic [3:0]       WA3W,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic             busy,
  output logic [CNT_W-1:0] stallCount
);

  state_t           state_q, state_d;
  logic [3:0]       ra1E_q, ra2E_q;
  logic             use1E_q, use2E_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             ld_stall;
  fwd_t             fwd_a, fwd_b;

  assign ld_stall = regWriteE && memToRegE &&
                    ((useRa1D && (WA3E == ra1D) && (ra1D != PC_REG)) ||
                     (useRa2D && (WA3E == ra2D) && (ra2D != PC_REG)));

  always_comb begin
    state_d = state_q;
    stallF  = 1'b0;
    stallD  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    case (state_q)
      RUN: begin
        // PCSrcW drives the PC mux, so fetch must never be held that cycle.
        stallF = ld_stall && !PCSrcW;
        stallD = ld_stall;
        flushE = ld_stall;
        if (PCSrcD && !ld_stall) begin
          state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        stallF = !PCSrcW;
        flushD = 1'b1;
        if (PCSrcW) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ra1E_q      <= 4'd0;
      ra2E_q      <= 4'd0;
      use1E_q     <= 1'b0;
      use2E_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      // A bubble only drops the read enables; stale addresses are harmless.
      if (flushE) begin
        use1E_q <= 1'b0;
        use2E_q <= 1'b0;
      end else begin
        ra1E_q  <= ra1D;
        ra2E_q  <= ra2D;
        use1E_q <= useRa1D;
        use2E_q <= useRa2D;
      end
    end
  end

  fwd_sel #(.PC_REG_IDX(PC_REG)) u_fwd_a (
    .ra_e_i       (ra1E_q),
    .use_e_i      (use1E_q),
    .wa3_m_i      (WA3M),
    .reg_write_m_i(regWriteM),
    .wa3_w_i      (WA3W),
    .reg_write_w_i(regWriteW),
    .sel_o        (fwd_a)
  );

  fwd_sel #(.PC_REG_IDX(PC_REG)) u_fwd_b (
    .ra_e_i       (ra2E_q),
    .use_e_i      (use2E_q),
    .wa3_m_i      (WA3M),
    .reg_write_m_i(regWriteM),
    .wa3_w_i      (WA3W),
    .reg_write_w_i(regWriteW),
    .sel_o        (fwd_b)
  );

  assign fwdAE      = fwd_a;
  assign fwdBE      = fwd_b;
  assign busy       = (state_q != RUN);
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cycle table, counter saturation run,
// then randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [3:0] ra1D, ra2D;
    logic       u1, u2, pcD, rwE, m2rE;
    logic [3:0] wa3E;
    logic       rwM;
    logic [3:0] wa3M;
    logic       rwW, pcW;
    logic [3:0] wa3W;
  } in_t;

  typedef struct packed {
    logic        sF, sD, fD, fE;
    logic [1:0]  fA, fB;
    logic        busy;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  ra1D, ra2D, WA3E, WA3M, WA3W;
  logic        useRa1D, useRa2D, PCSrcD, regWriteE, memToRegE;
  logic        regWriteM, regWriteW, PCSrcW;
  logic        stallF, stallD, flushD, flushE, busy;
  logic [1:0]  fwdAE, fwdBE;
  logic [15:0] stallCount;
  out_t        act;

  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl[$];

  // Reference model state
  bit   m_br;
  int   m_ra1, m_ra2, m_cnt;
  bit   m_u1, m_u2;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ra1D(ra1D), .ra2D(ra2D), .useRa1D(useRa1D), .useRa2D(useRa2D),
    .PCSrcD(PCSrcD), .regWriteE(regWriteE), .memToRegE(memToRegE), .WA3E(WA3E),
    .regWriteM(regWriteM), .WA3M(WA3M), .regWriteW(regWriteW), .PCSrcW(PCSrcW),
    .WA3W(WA3W), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .fwdAE(fwdAE), .fwdBE(fwdBE), .busy(busy), .stallCount(stallCount)
  );

  assign act = {stallF, stallD, flushD, flushE, fwdAE, fwdBE, busy, stallCount};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t I(int r, int a1, int a2, int u1, int u2, int pcd,
                            int rwe, int m2r, int wae, int rwm, int wam,
                            int rww, int pcw, int waw);
    in_t x;
    x.rst = 1'(r);    x.ra1D = 4'(a1); x.ra2D = 4'(a2);
    x.u1 = 1'(u1);    x.u2 = 1'(u2);   x.pcD = 1'(pcd);
    x.rwE = 1'(rwe);  x.m2rE = 1'(m2r); x.wa3E = 4'(wae);
    x.rwM = 1'(rwm);  x.wa3M = 4'(wam);
    x.rwW = 1'(rww);  x.pcW = 1'(pcw); x.wa3W = 4'(waw);
    return x;
  endfunction

  function automatic out_t O(int sf, int sd, int fd, int fe, int fa, int fb,
                             int bz, int cnt);
    out_t y;
    y.sF = 1'(sf); y.sD = 1'(sd); y.fD = 1'(fd); y.fE = 1'(fe);
    y.fA = 2'(fa); y.fB = 2'(fb); y.busy = 1'(bz); y.cnt = 16'(cnt);
    return y;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t x);
    rst = x.rst;  ra1D = x.ra1D; ra2D = x.ra2D; useRa1D = x.u1; useRa2D = x.u2;
    PCSrcD = x.pcD; regWriteE = x.rwE; memToRegE = x.m2rE; WA3E = x.wa3E;
    regWriteM = x.rwM; WA3M = x.wa3M; regWriteW = x.rwW; PCSrcW = x.pcW;
    WA3W = x.wa3W;
  endtask

  task automatic chk(input string nm, input out_t a, input out_t e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got sF=%b sD=%b fD=%b fE=%b fA=%b fB=%b busy=%b cnt=%0d, want sF=%b sD=%b fD=%b fE=%b fA=%b fB=%b busy=%b cnt=%0d",
               nm, a.sF, a.sD, a.fD, a.fE, a.fA, a.fB, a.busy, a.cnt,
               e.sF, e.sD, e.fD, e.fE, e.fA, e.fB, e.busy, e.cnt);
    end
  endtask

  function automatic logic [3:0] pick();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  function automatic logic [1:0] ref_fwd(bit en, int ra, in_t x);
    if (!en || ra == 15) return 2'b00;
    if (x.rwM && int'(x.wa3M) == ra) return 2'b10;
    if (x.rwW && int'(x.wa3W) == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t ref_out(in_t x);
    out_t y;
    bit   ld;
    ld = x.rwE && x.m2rE &&
         ((x.u1 && x.wa3E == x.ra1D && x.ra1D != 4'd15) ||
          (x.u2 && x.wa3E == x.ra2D && x.ra2D != 4'd15));
    if (m_br) begin
      y.sF = !x.pcW; y.sD = 1'b0; y.fD = 1'b1; y.fE = 1'b0; y.busy = 1'b1;
    end else begin
      y.sF = ld && !x.pcW; y.sD = ld; y.fD = 1'b0; y.fE = ld; y.busy = 1'b0;
    end
    y.fA  = ref_fwd(m_u1, m_ra1, x);
    y.fB  = ref_fwd(m_u2, m_ra2, x);
    y.cnt = 16'(m_cnt);
    return y;
  endfunction

  task automatic ref_step(in_t x, out_t y);
    if (x.rst) begin
      m_br = 0; m_ra1 = 0; m_ra2 = 0; m_u1 = 0; m_u2 = 0; m_cnt = 0;
    end else begin
      if (y.sF && m_cnt < 65535) m_cnt++;
      if (y.fE) begin
        m_u1 = 0; m_u2 = 0;
      end else begin
        m_ra1 = int'(x.ra1D); m_ra2 = int'(x.ra2D); m_u1 = x.u1; m_u2 = x.u2;
      end
      if (m_br) m_br = !x.pcW;
      else      m_br = x.pcD && !y.sD;
    end
  endtask

  initial begin
    in_t  idle, x;
    out_t e;
    idle = I(0,0,0,0,0,0,0,0,0,0,0,0,0,0);

    // Inputs: rst,ra1D,ra2D,u1,u2,pcD,rwE,m2rE,WA3E,rwM,WA3M,rwW,pcW,WA3W
    // Expect: sF,sD,fD,fE,fA,fB,busy,cnt
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,0)); // idle after reset
    add(I(0, 3,0,1,0,0,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,0));
    add(I(0, 3,0,1,0,0,0,0,0,1, 3,0,0, 0), O(0,0,0,0,2,0,0,0)); // M forward
    add(I(0,15,0,1,0,0,0,0,0,1, 3,1,0, 3), O(0,0,0,0,2,0,0,0)); // M beats W
    add(I(0, 3,0,1,0,0,0,0,0,1,15,1,0,15), O(0,0,0,0,0,0,0,0)); // PC never forwarded
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,1,0, 3), O(0,0,0,0,1,0,0,0)); // W forward
    add(I(0, 0,5,0,1,0,1,1,5,0, 0,0,0, 0), O(1,1,0,1,0,0,0,0)); // load-use
    add(I(0, 0,5,0,1,0,0,0,0,1, 5,0,0, 0), O(0,0,0,0,0,0,0,1)); // single stall
    add(I(0, 0,0,0,0,0,0,0,0,1, 5,0,0, 0), O(0,0,0,0,0,2,0,1)); // load forwarded from M
    add(I(0, 0,0,0,0,1,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,1)); // branch in decode
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(1,0,1,0,0,0,1,1));
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(1,0,1,0,0,0,1,2));
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(1,0,1,0,0,0,1,3));
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,1, 0), O(0,0,1,0,0,0,1,4)); // PCSrcW releases
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,4));
    add(I(0, 7,0,1,0,1,1,1,7,0, 0,0,0, 0), O(1,1,0,1,0,0,0,4)); // branch + load-use
    add(I(0, 7,0,1,0,1,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,5));
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(1,0,1,0,0,0,1,5));
    add(I(0, 7,0,1,0,0,1,1,7,0, 0,0,0, 0), O(1,0,1,0,0,0,1,6)); // ldStall ignored
    add(I(0, 0,0,0,0,0,0,0,0,1, 7,0,1, 0), O(0,0,1,0,2,0,1,7));
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,1, 0), O(0,0,0,0,0,0,0,7)); // stray PCSrcW in RUN
    add(I(0, 0,2,0,1,0,1,1,2,0, 0,0,1, 0), O(0,1,0,1,0,0,0,7)); // PCSrcW masks stallF
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,7));
    add(I(0, 0,0,0,0,1,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,7));
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(1,0,1,0,0,0,1,7));
    add(I(1, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(1,0,1,0,0,0,1,8)); // reset mid BR_WAIT
    add(I(0, 0,0,0,0,0,0,0,0,0, 0,0,0, 0), O(0,0,0,0,0,0,0,0));
    add(I(1, 4,0,1,0,0,1,1,4,0, 0,0,0, 0), O(1,1,0,1,0,0,0,0)); // reset mid stall
    add(I(0, 0,0,0,0,0,0,0,0,1, 0,0,0, 0), O(0,0,0,0,0,0,0,0));

    x = idle;
    x.rst = 1'b1;
    drive(x);
    @(negedge clk);
    @(negedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i);
      #1;
      chk($sformatf("row%0d", k), act, tbl[k].o);
      @(negedge clk);
    end

    // Hold BR_WAIT long enough to push the counter past saturation.
    x = idle;
    x.pcD = 1'b1;
    drive(x);
    @(negedge clk);
    drive(idle);
    #1;
    chk("sat_start", act, O(1,0,1,0,0,0,1,0));
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_fffe", act, O(1,0,1,0,0,0,1,65534));
    @(negedge clk);
    #1;
    chk("sat_ffff", act, O(1,0,1,0,0,0,1,65535));
    repeat (6) @(negedge clk);
    #1;
    chk("sat_hold", act, O(1,0,1,0,0,0,1,65535));
    x = idle;
    x.pcW = 1'b1;
    drive(x);
    #1;
    chk("sat_exit", act, O(0,0,1,0,0,0,1,65535));
    @(negedge clk);
    drive(idle);
    #1;
    chk("sat_run", act, O(0,0,0,0,0,0,0,65535));

    // Randomized traffic against the reference model.
    x = idle;
    x.rst = 1'b1;
    @(negedge clk);
    drive(x);
    @(negedge clk);
    m_br = 0; m_ra1 = 0; m_ra2 = 0; m_u1 = 0; m_u2 = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      x.rst  = ($urandom_range(0, 49) == 0);
      x.ra1D = pick();
      x.ra2D = pick();
      x.u1   = 1'($urandom_range(0, 1));
      x.u2   = 1'($urandom_range(0, 1));
      x.pcD  = ($urandom_range(0, 3) == 0);
      x.rwE  = 1'($urandom_range(0, 1));
      x.m2rE = 1'($urandom_range(0, 1));
      x.wa3E = pick();
      x.rwM  = 1'($urandom_range(0, 1));
      x.wa3M = pick();
      x.rwW  = 1'($urandom_range(0, 1));
      x.wa3W = pick();
      x.pcW  = m_br ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      drive(x);
      #1;
      e = ref_out(x);
      chk($sformatf("rand%0d", n), act, e);
      ref_step(x, e);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
